// File: rtl/life_sequencer_if.sv
// ----------------------------------------------------------------------------
// life_sequencer_if
// Control/status bundle between the Game of Life sequencer and its environment
// (pulse inputs, grid observation buses, grid mux/enable and status outputs).
//
// Signals:
//   seed_load/start/halt/step  one-cycle control pulses
//   period      RUN dwell cycles per generation (0 treated as 1)
//   grid_q      current 8x8 grid register contents
//   grid_next   evolve-network output for grid_q
//   sel         grid mux select (0 = seed, 1 = grid_next)
//   grid_en     grid register load enable
//   running     free-running evolution in progress
//   gen_count   generations since last seed load (saturating)
//   stable      sticky: last evolve was a still life
//   extinct     sticky: last evolve produced an empty board
//
// Modports: master = environment/controller host, slave = sequencer.
// ----------------------------------------------------------------------------
interface life_sequencer_if #(
   parameter int PERIOD_W = 24,
   parameter int GEN_W    = 16
);
   logic                seed_load;
   logic                start;
   logic                halt;
   logic                step;
   logic [PERIOD_W-1:0] period;
   logic [63:0]         grid_q;
   logic [63:0]         grid_next;
   logic                sel;
   logic                grid_en;
   logic                running;
   logic [GEN_W-1:0]    gen_count;
   logic                stable;
   logic                extinct;

   modport master (
      output seed_load, start, halt, step, period, grid_q, grid_next,
      input  sel, grid_en, running, gen_count, stable, extinct
   );

   modport slave (
      input  seed_load, start, halt, step, period, grid_q, grid_next,
      output sel, grid_en, running, gen_count, stable, extinct
   );
endinterface

// File: rtl/life_sequencer.sv
// ----------------------------------------------------------------------------
// life_sequencer
// Run/step/pause controller for an external 8x8 Game of Life grid register and
// evolve network. Loads a seed, advances generations free-running at a
// programmable period or one step at a time, counts generations and stops by
// itself on extinction or a still life.
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-low reset
//   bus    life_sequencer_if.slave (pulses, period, grid_q/grid_next in;
//          sel, grid_en, running, gen_count, stable, extinct out)
// ----------------------------------------------------------------------------
module life_sequencer #(
   parameter int PERIOD_W = 24,
   parameter int GEN_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   life_sequencer_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_PAUSED, S_RUN, S_EVOLVE, S_DONE
   } state_t;

   state_t              state, state_nxt;
   logic [PERIOD_W-1:0] timer;
   logic [PERIOD_W-1:0] period_m1;
   logic [GEN_W-1:0]    gen_count;
   logic                stable, extinct, run_mode;
   logic                timer_hit, evo_zero, evo_same;

   // period of 0 behaves like 1, so the terminal count is never below zero
   assign period_m1 = (bus.period == '0) ? '0 : bus.period - PERIOD_W'(1);
   assign timer_hit = (timer == period_m1);
   assign evo_zero  = (bus.grid_next == 64'd0);
   assign evo_same  = (bus.grid_next == bus.grid_q);

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // ----------------------------------------------------------- next state
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (bus.seed_load) state_nxt = S_LOAD;
         S_LOAD:   state_nxt = S_PAUSED;
         S_PAUSED: begin
            if      (bus.seed_load) state_nxt = S_LOAD;
            else if (bus.start)     state_nxt = S_RUN;
            else if (bus.step)      state_nxt = S_EVOLVE;
         end
         S_RUN: begin
            if      (bus.seed_load) state_nxt = S_LOAD;
            else if (bus.halt)      state_nxt = S_PAUSED;
            else if (timer_hit)     state_nxt = S_EVOLVE;
         end
         S_EVOLVE: begin
            // terminal conditions outrank halt so a dying board always ends in DONE
            if      (bus.seed_load)    state_nxt = S_LOAD;
            else if (evo_zero)         state_nxt = S_DONE;
            else if (evo_same)         state_nxt = S_DONE;
            else if (bus.halt)         state_nxt = S_PAUSED;
            else if (run_mode)         state_nxt = S_RUN;
            else                       state_nxt = S_PAUSED;
         end
         S_DONE:   if (bus.seed_load) state_nxt = S_LOAD;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // ------------------------------------------- timer / counter / flags
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         timer     <= '0;
         gen_count <= '0;
         stable    <= 1'b0;
         extinct   <= 1'b0;
         run_mode  <= 1'b0;
      end else begin
         case (state)
            S_LOAD: begin
               gen_count <= '0;
               stable    <= 1'b0;
               extinct   <= 1'b0;
               run_mode  <= 1'b0;
            end
            S_PAUSED: begin
               if (!bus.seed_load && bus.start) begin
                  timer    <= '0;
                  run_mode <= 1'b1;
               end
            end
            S_RUN: begin
               if (!bus.seed_load) begin
                  if (bus.halt)      run_mode <= 1'b0;
                  else if (timer_hit) timer   <= '0;
                  else               timer    <= timer + PERIOD_W'(1);
               end
            end
            S_EVOLVE: begin
               if (!(&gen_count)) gen_count <= gen_count + GEN_W'(1);
               if (!bus.seed_load) begin
                  // extinct takes precedence when an empty board stays empty
                  if      (evo_zero) extinct  <= 1'b1;
                  else if (evo_same) stable   <= 1'b1;
                  else if (bus.halt) run_mode <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   // -------------------------------------------------------------- outputs
   always_comb begin
      bus.sel     = 1'b0;
      bus.grid_en = 1'b0;
      bus.running = 1'b0;
      case (state)
         S_LOAD:   bus.grid_en = 1'b1;
         S_RUN:    bus.running = 1'b1;
         S_EVOLVE: begin
            bus.sel     = 1'b1;
            bus.grid_en = 1'b1;
            bus.running = run_mode;
         end
         default: ;
      endcase
   end

   assign bus.gen_count = gen_count;
   assign bus.stable    = stable;
   assign bus.extinct   = extinct;

endmodule

// File: tb/tb_life_sequencer.sv
// ----------------------------------------------------------------------------
// tb_life_sequencer
// Drives two sequencers from one stimulus stream (GEN_W=16 and GEN_W=4, the
// latter to observe counter saturation). Each operation predicts the grid
// writes it will cause (cycle, mux select, data, status at that moment) from
// the generation schedule arithmetic and pushes them into a scoreboard; a
// monitor pops one entry per observed grid write.
// ----------------------------------------------------------------------------
module tb_life_sequencer;
   localparam int PW = 24;
   localparam int GW = 16;
   localparam int SAT_MAX = 15;

   localparam int M_IDLE = 0, M_PAUSED = 1, M_DONE = 2;

   localparam logic [63:0] BLINKER = 64'h0000_0000_0038_0000;
   localparam logic [63:0] BLOCK   = 64'h0000_0000_1818_0000;
   localparam logic [63:0] SINGLE  = 64'h0000_0000_0000_0100;
   localparam logic [63:0] GLIDER  = 64'h0000_0000_0007_0402;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   life_sequencer_if #(.PERIOD_W(PW), .GEN_W(GW)) m_if ();
   life_sequencer_if #(.PERIOD_W(PW), .GEN_W(4))  s_if ();

   life_sequencer #(.PERIOD_W(PW), .GEN_W(GW)) dut (.clk(clk), .reset(rst_n), .bus(m_if));
   life_sequencer #(.PERIOD_W(PW), .GEN_W(4))  dut_sat (.clk(clk), .reset(rst_n), .bus(s_if));

   // ---------------------------------------------------------------- world
   function automatic logic [63:0] life(input logic [63:0] g);
      logic [63:0] nx;
      int n, rr, cc;
      nx = '0;
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++) begin
            n = 0;
            for (int dr = -1; dr <= 1; dr++)
               for (int dc = -1; dc <= 1; dc++) begin
                  rr = r + dr; cc = c + dc;
                  if ((dr != 0 || dc != 0) && rr >= 0 && rr < 8 && cc >= 0 && cc < 8)
                     n += g[rr*8+cc] ? 1 : 0;
               end
            nx[r*8+c] = (n == 3) || (n == 2 && g[r*8+c]);
         end
      return nx;
   endfunction

   logic [63:0] grid_q = '0;
   logic [63:0] seed_val = '0;
   always @(posedge clk)
      if (m_if.grid_en) grid_q <= m_if.sel ? m_if.grid_next : seed_val;

   assign m_if.grid_q    = grid_q;
   assign m_if.grid_next = life(grid_q);
   assign s_if.grid_q    = grid_q;
   assign s_if.grid_next = life(grid_q);
   assign s_if.seed_load = m_if.seed_load;
   assign s_if.start     = m_if.start;
   assign s_if.halt      = m_if.halt;
   assign s_if.step      = m_if.step;
   assign s_if.period    = m_if.period;

   int pe = 0;  // index of the most recent rising edge = current cycle
   always @(posedge clk) pe <= pe + 1;

   // ----------------------------------------------------------- scoreboard
   typedef struct {
      int          cyc;
      bit          sel;
      logic [63:0] data;
      int          gen;
      bit          run;
      bit          stb;
      bit          ext;
   } ev_t;
   ev_t sb[$];

   int total = 0;
   int bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int sat(input int g);
      return (g > SAT_MAX) ? SAT_MAX : g;
   endfunction

   initial begin
      ev_t e;
      forever begin
         @(negedge clk);
         if (rst_n && (m_if.grid_en || s_if.grid_en)) begin
            if (sb.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_write actual=cycle %0d required=no write", pe);
            end else begin
               e = sb.pop_front();
               chk("wr_cycle",   pe, e.cyc);
               chk("wr_sel",     m_if.sel, e.sel);
               chk("wr_data",    m_if.sel ? m_if.grid_next : seed_val, e.data);
               chk("wr_gen",     m_if.gen_count, e.gen);
               chk("wr_running", m_if.running, e.run);
               chk("wr_stable",  m_if.stable, e.stb);
               chk("wr_extinct", m_if.extinct, e.ext);
               chk("sat_wr_en",  s_if.grid_en, 1);
               chk("sat_wr_gen", s_if.gen_count, sat(e.gen));
            end
         end
      end
   end

   // ---------------------------------------------------------------- model
   logic [63:0] mg;
   int  mgen = 0;
   bit  mstb = 0, mext = 0;
   int  mode = M_IDLE;

   function automatic bit evolve(input int c, input bit run);
      logic [63:0] nx;
      nx = life(mg);
      sb.push_back('{c, 1'b1, nx, mgen, run, mstb, mext});
      mgen++;
      if (nx == 64'd0)  begin mg = nx; mext = 1; return 1; end
      if (nx == mg)     begin mstb = 1; return 1; end
      mg = nx;
      return 0;
   endfunction

   // ------------------------------------------------------------- stimulus
   task automatic slot(output int n);
      @(negedge clk); #1;
      n = pe + 1;  // edge that will sample what is driven now
   endtask

   task automatic pulse_end();
      @(posedge clk); #1;
      m_if.seed_load = 0; m_if.start = 0; m_if.halt = 0; m_if.step = 0;
   endtask

   task automatic check_state(input string tag);
      chk({tag, "_gen"},     m_if.gen_count, mgen);
      chk({tag, "_sat_gen"}, s_if.gen_count, sat(mgen));
      chk({tag, "_stable"},  m_if.stable, mstb);
      chk({tag, "_extinct"}, m_if.extinct, mext);
      chk({tag, "_running"}, m_if.running, 0);
   endtask

   task automatic seed_op(input logic [63:0] s, input bit with_step);
      int n;
      slot(n);
      sb.push_back('{n, 1'b0, s, mgen, 1'b0, mstb, mext});
      seed_val = s;
      m_if.seed_load = 1; m_if.step = with_step;
      pulse_end();
      mg = s; mgen = 0; mstb = 0; mext = 0; mode = M_PAUSED;
      repeat (2) @(posedge clk);
   endtask

   task automatic step_op();
      int n;
      slot(n);
      if (mode == M_PAUSED) mode = evolve(n, 0) ? M_DONE : M_PAUSED;
      m_if.step = 1;
      pulse_end();
      repeat (2) @(posedge clk);
   endtask

   // term: 0 halt, 1 reseed, 2 async reset, 3 halt+start together
   task automatic run_op(input int p, input int dur, input int term);
      int n, m, pe1;
      bit done;
      pe1 = (p == 0) ? 1 : p;
      done = 0;
      slot(n);
      if (mode == M_PAUSED) begin
         // evolve k lands on cycle n-1+k*(P+1); only those before the terminating edge happen
         for (int k = 1; n - 1 + k*(pe1+1) <= n + dur - 1; k++)
            if (evolve(n - 1 + k*(pe1+1), 1)) begin done = 1; break; end
         mode = done ? M_DONE : M_PAUSED;
      end
      m_if.period = PW'(p);
      m_if.start = 1;
      pulse_end();
      if (term == 2) begin
         repeat (dur) @(posedge clk);
         #2 rst_n = 0;
         #1;
         chk("rst_sel",     m_if.sel, 0);
         chk("rst_grid_en", m_if.grid_en, 0);
         chk("rst_running", m_if.running, 0);
         chk("rst_gen",     m_if.gen_count, 0);
         chk("rst_stable",  m_if.stable, 0);
         chk("rst_extinct", m_if.extinct, 0);
         chk("rst_sat_en",  s_if.grid_en, 0);
         mgen = 0; mstb = 0; mext = 0; mode = M_IDLE;
         repeat (2) @(negedge clk);
         rst_n = 1;
         repeat (2) @(posedge clk);
      end else if (term == 1) begin
         repeat (dur - 1) @(posedge clk);
         seed_op(GLIDER, 0);
      end else begin
         repeat (dur - 1) @(posedge clk);
         slot(m);
         m_if.halt = 1; m_if.start = (term == 3);
         pulse_end();
         repeat (3) @(posedge clk);
      end
   endtask

   logic [63:0] pats [5];

   initial begin
      m_if.seed_load = 0; m_if.start = 0; m_if.halt = 0; m_if.step = 0;
      m_if.period = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("por_grid_en", m_if.grid_en, 0);
      chk("por_sel",     m_if.sel, 0);
      check_state("por");
      @(negedge clk) rst_n = 1;

      // IDLE ignores everything except seed_load
      step_op();
      run_op(2, 6, 0);
      check_state("idle");

      // blinker, period 3: five generations in the first 20 run cycles
      seed_op(BLINKER, 0);
      check_state("seeded");
      run_op(3, 21, 0);
      check_state("blinker");
      chk("blinker_gen5", m_if.gen_count, 5);
      chk("blinker_osc", grid_q, life(BLINKER));

      // still life via single step, then DONE ignores start
      seed_op(BLOCK, 0);
      step_op();
      check_state("block");
      chk("block_stable", m_if.stable, 1);
      run_op(1, 8, 0);
      check_state("done_start");

      // extinction with period 0
      seed_op(SINGLE, 0);
      run_op(0, 6, 0);
      check_state("extinct");
      chk("extinct_flag", m_if.extinct, 1);

      // priorities: halt beats start in RUN, seed_load beats step in PAUSED
      seed_op(BLINKER, 0);
      run_op(2, 8, 3);
      check_state("halt_start");
      run_op(1, 3, 0);
      seed_op(GLIDER, 1);
      check_state("seed_step");

      // saturation of the narrow counter
      seed_op(BLINKER, 0);
      run_op(1, 41, 0);
      check_state("sat");
      chk("sat_hold15", s_if.gen_count, 15);

      // reset in the middle of a run, then recovery
      seed_op(BLINKER, 0);
      run_op(2, 7, 2);
      check_state("post_rst");
      seed_op(BLINKER, 0);
      check_state("reseed");

      // randomized operation mix
      pats[0] = BLINKER; pats[1] = BLOCK; pats[2] = SINGLE; pats[3] = GLIDER;
      for (int i = 0; i < 30; i++) begin
         pats[4] = {$urandom, $urandom};
         case ($urandom_range(0, 3))
            0: seed_op(pats[$urandom_range(0, 4)], 0);
            1: step_op();
            2: run_op($urandom_range(0, 5), $urandom_range(1, 25), 0);
            default: run_op($urandom_range(0, 5), $urandom_range(1, 25), 1);
         endcase
         check_state("rand");
      end

      repeat (5) @(posedge clk);
      chk("sb_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
